// File: rtl/imem_dmem_2port_loader.sv
// rtl/imem_dmem_2port_loader.sv - dual-port word memory with streaming boot loader
//
// Port A: read-only fetch port (en_a, flush_a, addr_a -> rd_a, err_a).
// Port B: read/write data port with byte enables (en_b, flush_b, we_b, be_b,
//         addr_b, wd_b -> rd_b, err_b).
// Loader: ld_start, ld_valid/ld_data/ld_last in, ld_ready/busy/ld_count out.
// Clock clk, synchronous active-high reset rst. Array contents survive reset.
module imem_dmem_2port_loader #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_a,
  input  logic                       flush_a,
  input  logic [WIDTH-1:0]           addr_a,
  output logic [WIDTH-1:0]           rd_a,
  output logic                       err_a,
  input  logic                       en_b,
  input  logic                       flush_b,
  input  logic                       we_b,
  input  logic [WIDTH/8-1:0]         be_b,
  input  logic [WIDTH-1:0]           addr_b,
  input  logic [WIDTH-1:0]           wd_b,
  output logic [WIDTH-1:0]           rd_b,
  output logic                       err_b,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [WIDTH-1:0]           ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic                       busy,
  output logic [$clog2(LENGTH):0]    ld_count
);

  localparam int NBYTES = WIDTH / 8;
  localparam int AW     = $clog2(LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  logic [WIDTH-1:0] mem [LENGTH];

  state_t        state, state_n;
  logic [AW:0]   count_n;
  logic          ld_we;
  logic          bad_a, bad_b, wr_b;
  logic [AW-1:0] idx_a, idx_b;

  // Misaligned or any address bit above the array's word index set.
  function automatic logic addr_bad(input logic [WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != '0);
  endfunction

  assign bad_a = addr_bad(addr_a);
  assign bad_b = addr_bad(addr_b);
  assign idx_a = addr_a[AW+1:2];
  assign idx_b = addr_b[AW+1:2];

  // The loader owns the array while busy, so port B writes are blocked then.
  assign wr_b = en_b && we_b && !bad_b && !busy;

  always_comb begin
    state_n = state;
    count_n = ld_count;
    ld_we   = 1'b0;
    case (state)
      S_LOAD: begin
        if (ld_valid && ld_ready) begin
          ld_we   = 1'b1;
          count_n = ld_count + 1'b1;
          // Stop at ld_last or when the array is full; extra words never land.
          if (ld_last || count_n == (AW+1)'(LENGTH)) begin
            state_n = S_DONE;
          end
        end
      end
      default: begin
        if (ld_start) begin
          state_n = S_LOAD;
          count_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ld_count <= '0;
      busy     <= 1'b0;
      ld_ready <= 1'b0;
    end else begin
      state    <= state_n;
      ld_count <= count_n;
      busy     <= (state_n == S_LOAD);
      ld_ready <= (state_n == S_LOAD);
    end
  end

  // Array writes; reset only suppresses the write of that cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_we) begin
        mem[ld_count[AW-1:0]] <= ld_data;
      end else if (wr_b) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (be_b[i]) begin
            mem[idx_b][8*i +: 8] <= wd_b[8*i +: 8];
          end
        end
      end
    end
  end

  // Registered reads see the pre-write word, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a  <= '0;
      err_a <= 1'b0;
    end else if (flush_a) begin
      rd_a  <= '0;
      err_a <= 1'b0;
    end else if (en_a) begin
      if (busy) begin
        rd_a  <= '0;
        err_a <= 1'b0;
      end else if (bad_a) begin
        rd_a  <= '0;
        err_a <= 1'b1;
      end else begin
        rd_a  <= mem[idx_a];
        err_a <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_b  <= '0;
      err_b <= 1'b0;
    end else if (flush_b) begin
      rd_b  <= '0;
      err_b <= 1'b0;
    end else if (en_b) begin
      if (busy) begin
        rd_b  <= '0;
        err_b <= 1'b0;
      end else if (bad_b) begin
        rd_b  <= '0;
        err_b <= 1'b1;
      end else begin
        rd_b  <= mem[idx_b];
        err_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_2port_loader.sv
// tb/tb_imem_dmem_2port_loader.sv - scoreboard bench for imem_dmem_2port_loader
module tb_imem_dmem_2port_loader;

  localparam int LEN = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, flush_a, en_b, flush_b, we_b;
  logic [31:0] addr_a, addr_b, wd_b, ld_data;
  logic [3:0]  be_b;
  logic        ld_start, ld_valid, ld_last;
  logic [31:0] rd_a, rd_b;
  logic        err_a, err_b, ld_ready, busy;
  logic [8:0]  ld_count;

  always #5 clk = ~clk;

  imem_dmem_2port_loader #(.WIDTH(32), .LENGTH(LEN)) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .flush_a(flush_a), .addr_a(addr_a), .rd_a(rd_a), .err_a(err_a),
    .en_b(en_b), .flush_b(flush_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b),
    .wd_b(wd_b), .rd_b(rd_b), .err_b(err_b),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .busy(busy), .ld_count(ld_count)
  );

  typedef struct packed {
    logic [31:0] rd_a;
    logic        err_a;
    logic [31:0] rd_b;
    logic        err_b;
    logic        busy;
    logic        ld_ready;
    logic [8:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [31:0] m_mem [LEN];
  bit          m_load;
  int          m_cnt;
  logic [31:0] m_rd_a, m_rd_b;
  bit          m_err_a, m_err_b;

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * LEN);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clr();
    rst = 0; en_a = 0; flush_a = 0; en_b = 0; flush_b = 0; we_b = 0;
    be_b = 0; ld_start = 0; ld_valid = 0; ld_last = 0;
  endtask

  // Apply current inputs to the model, queue the expected post-edge outputs,
  // then let the DUT see the edge.
  task automatic step();
    exp_t e;
    bit   was;
    if (rst) begin
      m_load = 0; m_cnt = 0;
      m_rd_a = 0; m_err_a = 0; m_rd_b = 0; m_err_b = 0;
    end else begin
      was = m_load;
      if (flush_a) begin m_rd_a = 0; m_err_a = 0; end
      else if (en_a) begin
        if (was)                 begin m_rd_a = 0; m_err_a = 0; end
        else if (is_bad(addr_a)) begin m_rd_a = 0; m_err_a = 1; end
        else                     begin m_rd_a = m_mem[addr_a / 4]; m_err_a = 0; end
      end
      if (flush_b) begin m_rd_b = 0; m_err_b = 0; end
      else if (en_b) begin
        if (was)                 begin m_rd_b = 0; m_err_b = 0; end
        else if (is_bad(addr_b)) begin m_rd_b = 0; m_err_b = 1; end
        else                     begin m_rd_b = m_mem[addr_b / 4]; m_err_b = 0; end
      end
      if (en_b && we_b && !was && !is_bad(addr_b)) begin
        for (int i = 0; i < 4; i++)
          if (be_b[i]) m_mem[addr_b / 4][8*i +: 8] = wd_b[8*i +: 8];
      end
      if (was && ld_valid) begin
        m_mem[m_cnt] = ld_data;
        m_cnt++;
        if (ld_last || m_cnt == LEN) m_load = 0;
      end else if (!was && ld_start) begin
        m_load = 1; m_cnt = 0;
      end
    end
    e.rd_a = m_rd_a; e.err_a = m_err_a; e.rd_b = m_rd_b; e.err_b = m_err_b;
    e.busy = m_load; e.ld_ready = m_load; e.cnt = 9'(m_cnt);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] w = 32'($urandom_range(0, LEN - 1)) * 4;
    if (r == 0) return w + 32'($urandom_range(1, 3));
    if (r == 1) return ($urandom() & 32'hFFFF_FFFC) | 32'h400;
    return w;
  endfunction

  // Monitor: every cycle the DUT presents a result, compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_a", rd_a, e.rd_a);
        chk("err_a", 32'(err_a), 32'(e.err_a));
        chk("rd_b", rd_b, e.rd_b);
        chk("err_b", 32'(err_b), 32'(e.err_b));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("ld_ready", 32'(ld_ready), 32'(e.ld_ready));
        chk("ld_count", 32'(ld_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    addr_a = 0; addr_b = 0; wd_b = 0; ld_data = 0;
    clr(); rst = 1; step(); step();

    // Gapped 4-word load, then fetch word 2
    clr(); ld_start = 1; step();
    for (int i = 0; i < 4; i++) begin
      clr(); step();
      clr(); ld_valid = 1; ld_data = 32'h11 * (i + 1); ld_last = (i == 3); step();
    end
    clr(); step();
    clr(); en_a = 1; addr_a = 32'h8; step();
    clr(); step();

    // Full load without ld_last, then an extra word that must be refused
    clr(); ld_start = 1; step();
    for (int i = 0; i < LEN; i++) begin
      clr(); ld_valid = 1; ld_data = $urandom(); step();
    end
    clr(); ld_valid = 1; ld_data = 32'hDEAD_BEEF; step();
    clr(); en_a = 1; addr_a = 0; step();

    // Byte-enable write with collision read on port A
    clr(); ld_start = 1; step();
    clr(); ld_valid = 1; ld_data = 32'h0102_0304; step();
    clr(); ld_valid = 1; ld_data = 32'hAABB_CCDD; ld_last = 1; step();
    clr(); step();
    clr(); en_b = 1; we_b = 1; be_b = 4'b0101; addr_b = 32'h4; wd_b = 32'h1122_3344;
    en_a = 1; addr_a = 32'h4; step();
    clr(); en_b = 1; addr_b = 32'h4; en_a = 1; addr_a = 32'h4; step();

    // Misaligned / out-of-range on both ports; erroring write must not land
    clr(); en_a = 1; addr_a = 32'h6; en_b = 1; addr_b = 32'h400; step();
    clr(); en_b = 1; we_b = 1; be_b = 4'hF; addr_b = 32'h400; wd_b = 32'hCAFE_F00D; step();
    clr(); en_b = 1; addr_b = 32'h0; step();

    // Hold, flush priority, busy reads
    clr(); en_a = 1; addr_a = 32'h8; step();
    for (int i = 0; i < 3; i++) begin clr(); addr_a = 32'hC; step(); end
    clr(); en_a = 1; flush_a = 1; addr_a = 32'h8; step();
    clr(); en_a = 1; addr_a = 32'h8; step();
    clr(); ld_start = 1; step();
    clr(); en_a = 1; addr_a = 32'h8; en_b = 1; we_b = 1; be_b = 4'hF; addr_b = 32'h10;
    ld_valid = 1; ld_data = 32'h5555_AAAA; ld_last = 1; step();
    clr(); en_a = 1; addr_a = 32'h0; en_b = 1; addr_b = 32'h10; step();

    // Reset mid-load after 2 of 5 words
    clr(); ld_start = 1; step();
    for (int i = 0; i < 2; i++) begin
      clr(); ld_valid = 1; ld_data = 32'h7000_0000 + 32'(i); step();
    end
    clr(); rst = 1; step();
    for (int i = 0; i < 3; i++) begin
      clr(); en_a = 1; addr_a = 32'(i * 4); en_b = 1; addr_b = 32'(i * 4); step();
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      clr();
      rst      = ($urandom_range(0, 199) == 0);
      en_a     = ($urandom_range(0, 3) != 0);
      flush_a  = ($urandom_range(0, 9) == 0);
      addr_a   = rand_addr();
      en_b     = ($urandom_range(0, 3) != 0);
      flush_b  = ($urandom_range(0, 9) == 0);
      we_b     = $urandom_range(0, 1);
      be_b     = 4'($urandom_range(0, 15));
      addr_b   = rand_addr();
      wd_b     = $urandom();
      ld_start = ($urandom_range(0, 39) == 0);
      ld_valid = ($urandom_range(0, 2) != 0);
      ld_data  = $urandom();
      ld_last  = ($urandom_range(0, 7) == 0);
      step();
    end
    clr(); step();

    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_dmem_2port_loader.md
Name: imem_dmem_2port_loader

Overview:
Parametrised single-clock, dual-port word memory that replaces the pipeline's read-only instruction store. Port A is the fetch port, read-only, with enable and flush. Port B is the data port, read/write with byte enables and the same enable and flush pipeline controls. A streaming boot loader FSM fills the array from address 0 before the core runs, and both ports report misaligned or out-of-range accesses.

Parameters:
WIDTH, 32, data and address width in bits; must be a multiple of 8 and at least 8.
LENGTH, 256, depth in words; a power of two of at least 2. AW = $clog2(LENGTH).
NBYTES, WIDTH/8, derived localparam (not overridable); number of byte lanes.

Ports:
clk  in  1  single clock for all logic.
rst  in  1  synchronous, active-high reset.
en_a  in  1  fetch read enable; output holds when low.
flush_a  in  1  zeroes rd_a on the next edge; has priority over en_a.
addr_a  in  WIDTH  fetch byte address.
rd_a  out  WIDTH  registered fetch data.
err_a  out  1  registered access-error flag for port A.
en_b  in  1  data port enable.
flush_b  in  1  zeroes rd_b on the next edge; has priority over en_b.
we_b  in  1  write strobe; effective only when en_b=1.
be_b  in  NBYTES  byte-lane write enables.
addr_b  in  WIDTH  data byte address.
wd_b  in  WIDTH  write data.
rd_b  out  WIDTH  registered read data.
err_b  out  1  registered access-error flag for port B.
ld_start  in  1  pulse to begin a load.
ld_valid  in  1  load word valid.
ld_data  in  WIDTH  load word.
ld_last  in  1  marks the final word of the load.
ld_ready  out  1  loader accepts a word when ld_valid & ld_ready.
busy  out  1  high while a load is in progress.
ld_count  out  AW+1  number of words written by the current or last load.

Behaviour:
- Reset: one clock `clk`; reset `rst` is synchronous and active-high. On reset, rd_a=0, rd_b=0, err_a=0, err_b=0, busy=0, ld_ready=0, ld_count=0, and the FSM goes to IDLE. Array contents are NOT cleared. Reset asserted mid-load aborts the load and keeps the words already written.
- Addressing: word index = addr[AW+1:2].
  - Misaligned: addr[1:0] != 0.
  - Out of range: any of addr[WIDTH-1:AW+2] set.
  - Either condition is an error.
- Read, ports A and B: 1-cycle latency.
  - flush=1: rd <= 0 and err <= 0.
  - Else en=1, no error: rd <= mem[index], err <= 0.
  - Else en=1, error: rd <= 0, err <= 1.
  - Else (en=0): rd and err hold.
- Write, port B: when en_b & we_b and there is no error, each lane i with be_b[i]=1 writes byte i of wd_b; other lanes are untouched.
  - An erroring write is suppressed and sets err_b.
  - rd_b on a write cycle returns the old word (read-first). flush_b does not suppress the write.
- Same-address collision: port A reading the word port B writes in the same cycle gets the old word.
- FSM IDLE -> LOAD on ld_start.
  - On entering LOAD: ld_count <= 0.
  - In LOAD: ld_ready=1 and busy=1. Each handshake writes ld_data to mem[ld_count] with all lanes and increments ld_count.
  - LOAD -> DONE on a handshake with ld_last=1, or on the handshake that makes ld_count == LENGTH. Extra words beyond LENGTH are never accepted.
  - DONE -> LOAD on ld_start (a reload). ld_start in LOAD is ignored.
  - busy and ld_ready are registered. They rise the cycle after ld_start and fall the cycle after the final handshake.
- While busy=1:
  - Port A and port B reads return 0 with err=0; flush and enable hold rules still apply.
  - Port B writes are blocked with err_b=0.
- ld_count holds its final value in DONE and IDLE until the next ld_start.

Test Plan:
- Reset, then ld_start; stream 4 words 0x11,0x22,0x33,0x44 with ld_last on the 4th and ld_valid gapped every other cycle -> busy high 2nd–last cycle, ld_count=4, DONE; fetch addr_a=0x8 with en_a -> rd_a=0x33 one cycle later.
- Load 0xAABBCCDD at word 1; port B write addr_b=0x4, be_b=4'b0101, wd_b=0x11223344 -> next read 0xAA22CC44; same-cycle rd_b = 0xAABBCCDD; simultaneous port A read of 0x4 = 0xAABBCCDD.
- addr_a=0x6 (misaligned) and addr_b=0x400 with LENGTH=256 -> rd=0 and err=1 on both ports; a write to 0x400 leaves memory unchanged.
- en_a=0 for 3 cycles after a valid read -> rd_a holds; flush_a and en_a both high -> rd_a=0; while busy, en_a=1 -> rd_a=0.
- Load LENGTH words without ld_last -> ld_ready drops after the 256th handshake, ld_count=256, and a 257th ld_valid is not accepted.
- rst asserted after 2 of 5 load words -> busy=0 and ld_count=0 next cycle; words 0–1 readable with the new data, word 2 retains its old value.
